// File: rtl/cam_capture_if.sv
// cam_capture_if: camera pixel bus in, frame-buffer write port and status out
interface cam_capture_if #(
    parameter int ADDR_W = 19
);
    logic              init_done;
    logic              cam_pclk;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              frame_done;
    logic              geom_err;

    modport master (
        output init_done, cam_pclk, cam_vsync, cam_href, cam_d,
        input  wr_en, wr_addr, wr_data, frame_done, geom_err
    );

    modport slave (
        input  init_done, cam_pclk, cam_vsync, cam_href, cam_d,
        output wr_en, wr_addr, wr_data, frame_done, geom_err
    );
endinterface

// File: rtl/cam_capture.sv
// cam_capture: locks to camera frames, pairs bytes into RGB565 writes, checks geometry
module cam_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input logic          clk_25m,
    input logic          rst,
    cam_capture_if.slave bus
);
    localparam int PW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [PW-1:0] H_MAX = PW'(H_ACTIVE);
    localparam logic [LW-1:0] V_MAX = LW'(V_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE} state_t;

    // synchroniser word layout: [10]=pclk [9]=vsync [8]=href [7:0]=data
    logic [10:0]       r_s1;
    logic [10:0]       r_s2;
    logic [2:0]        r_s3;
    state_t            r_state;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [PW-1:0]     r_pix_cnt;
    logic [LW-1:0]     r_line_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_wr_en;
    logic              r_frame_done;
    logic              r_geom_err;

    logic              w_pclk_rise;
    logic              w_vs_rise;
    logic              w_vs_fall;
    logic              w_href_fall;
    logic              w_byte;
    logic              w_line_has_pix;
    logic              w_pix_full;
    logic              w_lines_full;
    logic              w_short_line;
    logic [LW-1:0]     w_line_cnt_nx;
    logic [ADDR_W-1:0] w_line_pad;

    assign w_pclk_rise    = r_s2[10] & ~r_s3[2];
    assign w_vs_rise      = r_s2[9] & ~r_s3[1];
    assign w_vs_fall      = ~r_s2[9] & r_s3[1];
    assign w_href_fall    = ~r_s2[8] & r_s3[0];
    assign w_byte         = w_pclk_rise & r_s2[8];
    assign w_line_has_pix = r_pix_cnt != '0;
    assign w_pix_full     = r_pix_cnt == H_MAX;
    assign w_lines_full   = r_line_cnt == V_MAX;
    assign w_short_line   = w_line_has_pix & ~w_pix_full;
    // line count as it stands after this cycle's line end, so a coincident frame end sees it
    assign w_line_cnt_nx  = (w_href_fall && w_line_has_pix && !w_lines_full) ? r_line_cnt + LW'(1) : r_line_cnt;
    // distance from the current address to the next row boundary on a short line
    assign w_line_pad     = ADDR_W'(H_MAX - r_pix_cnt);

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_frame_done;
    assign bus.geom_err   = r_geom_err;

    // Bring the whole camera bus through one shared 2-flop chain plus an edge-detect stage
    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= {bus.cam_pclk, bus.cam_vsync, bus.cam_href, bus.cam_d};
            r_s2 <= r_s1;
            r_s3 <= r_s2[10:8];
        end
    end

    // Frame state machine: byte pairing, linear addressing and geometry checking
    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= 1'b0;
            r_hi         <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_addr       <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_geom_err   <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (!bus.init_done) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_WAIT_VS;
                    S_WAIT_VS: begin
                        if (w_vs_fall) begin
                            r_state    <= S_ACTIVE;
                            r_phase    <= 1'b0;
                            r_pix_cnt  <= '0;
                            r_line_cnt <= '0;
                            r_addr     <= '0;
                            r_geom_err <= 1'b0;
                        end
                    end
                    S_ACTIVE: begin
                        if (w_byte) begin
                            r_phase <= ~r_phase;
                            if (w_lines_full) begin
                                r_geom_err <= 1'b1;
                            end else if (!r_phase) begin
                                r_hi <= r_s2[7:0];
                            end else if (w_pix_full) begin
                                r_geom_err <= 1'b1;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_addr;
                                r_wr_data <= {r_hi, r_s2[7:0]};
                                r_addr    <= r_addr + ADDR_W'(1);
                                r_pix_cnt <= r_pix_cnt + PW'(1);
                            end
                        end
                        if (w_href_fall) begin
                            r_phase    <= 1'b0;
                            r_pix_cnt  <= '0;
                            r_line_cnt <= w_line_cnt_nx;
                            if (r_phase || w_short_line)
                                r_geom_err <= 1'b1;
                            if (w_short_line)
                                r_addr <= r_addr + w_line_pad;
                        end
                        if (w_vs_rise) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_WAIT_VS;
                            if (w_line_cnt_nx != V_MAX)
                                r_geom_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed frame vectors plus latency, reset and init_done sequences
module tb_cam_capture;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    typedef struct packed {
        logic [4:0]    nb0;
        logic [4:0]    nb1;
        logic [4:0]    nb2;
        logic [4:0]    nb3;
        logic [4:0]    n_wr;
        logic          err;
        logic [AW-1:0] a1;
        logic [AW-1:0] la;
        logic [15:0]   ld;
    } vec_t;

    logic clk_25m = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_fd = 0;
    logic [AW-1:0] wa [256];
    logic [15:0]   wd [256];
    vec_t vecs [6];

    cam_capture_if #(.ADDR_W(AW)) bus ();

    cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk_25m (clk_25m),
        .rst     (rst),
        .bus     (bus)
    );

    always #20 clk_25m = ~clk_25m;

    always @(negedge clk_25m) begin
        if (bus.wr_en) begin
            if (n_wr < 256) begin
                wa[n_wr] = bus.wr_addr;
                wd[n_wr] = bus.wr_data;
            end
            n_wr = n_wr + 1;
        end
        if (bus.frame_done)
            n_fd = n_fd + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25m);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.cam_d    = b;
        bus.cam_pclk = 1'b0;
        tick(2);
        bus.cam_pclk = 1'b1;
        tick(2);
    endtask

    task automatic send_line(input int n, inout logic [7:0] cnt);
        bus.cam_href = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) begin
            send_byte(cnt);
            cnt = cnt + 8'd1;
        end
        bus.cam_pclk = 1'b0;
        tick(2);
        bus.cam_href = 1'b0;
        tick(4);
    endtask

    task automatic vs_fall();
        bus.cam_vsync = 1'b1;
        tick(6);
        bus.cam_vsync = 1'b0;
        tick(6);
    endtask

    task automatic drive_frame(input vec_t v, output int i1);
        logic [7:0] cnt;
        int nb [4];
        nb[0] = int'(v.nb0);
        nb[1] = int'(v.nb1);
        nb[2] = int'(v.nb2);
        nb[3] = int'(v.nb3);
        cnt = '0;
        i1 = n_wr;
        vs_fall();
        for (int l = 0; l < 4; l++) begin
            if (l == 1) i1 = n_wr;
            if (nb[l] != 0) send_line(nb[l], cnt);
        end
        bus.cam_vsync = 1'b1;
        tick(8);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int b0, f0, i1;
        b0 = n_wr;
        f0 = n_fd;
        drive_frame(v, i1);
        chk($sformatf("v%0d_nwr", id), n_wr - b0, 32'(v.n_wr));
        chk($sformatf("v%0d_fdone", id), n_fd - f0, 1);
        chk($sformatf("v%0d_gerr", id), 32'(bus.geom_err), 32'(v.err));
        chk($sformatf("v%0d_addr0", id), 32'(wa[b0]), 0);
        chk($sformatf("v%0d_data0", id), 32'(wd[b0]), 32'h0001);
        chk($sformatf("v%0d_line1_addr", id), 32'(wa[i1]), 32'(v.a1));
        chk($sformatf("v%0d_last_addr", id), 32'(wa[n_wr - 1]), 32'(v.la));
        chk($sformatf("v%0d_last_data", id), 32'(wd[n_wr - 1]), 32'(v.ld));
    endtask

    initial begin
        int b0, f0, i1;
        logic [7:0] cnt;
        //           nb0    nb1    nb2    nb3    n_wr    err   a1     la      ld
        vecs[0] = '{5'd8,  5'd8,  5'd8,  5'd0,  5'd12, 1'b0, 4'd4, 4'd11, 16'h1617};
        vecs[1] = '{5'd9,  5'd8,  5'd8,  5'd0,  5'd12, 1'b1, 4'd4, 4'd11, 16'h1718};
        vecs[2] = '{5'd6,  5'd8,  5'd8,  5'd8,  5'd11, 1'b1, 4'd4, 4'd11, 16'h1415};
        vecs[3] = '{5'd8,  5'd8,  5'd8,  5'd0,  5'd12, 1'b0, 4'd4, 4'd11, 16'h1617};
        vecs[4] = '{5'd10, 5'd8,  5'd8,  5'd0,  5'd12, 1'b1, 4'd4, 4'd11, 16'h1819};
        vecs[5] = '{5'd8,  5'd8,  5'd0,  5'd0,  5'd8,  1'b1, 4'd4, 4'd7,  16'h0E0F};

        bus.init_done = 1'b0;
        bus.cam_pclk  = 1'b0;
        bus.cam_vsync = 1'b1;
        bus.cam_href  = 1'b0;
        bus.cam_d     = '0;
        tick(3);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_geom_err", 32'(bus.geom_err), 0);
        rst = 1'b0;
        tick(2);

        b0 = n_wr;
        f0 = n_fd;
        drive_frame(vecs[0], i1);
        chk("preinit_nwr", n_wr - b0, 0);
        chk("preinit_fdone", n_fd - f0, 0);

        bus.init_done = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], i);

        // write latency: edge k samples pclk high for the second byte
        b0 = n_wr;
        vs_fall();
        bus.cam_href = 1'b1;
        tick(2);
        send_byte(8'hA5);
        bus.cam_d    = 8'h3C;
        bus.cam_pclk = 1'b0;
        tick(2);
        bus.cam_pclk = 1'b1;
        tick(1);
        chk("lat_k", 32'(bus.wr_en), 0);
        tick(1);
        chk("lat_k1", 32'(bus.wr_en), 0);
        tick(1);
        chk("lat_k2", 32'(bus.wr_en), 1);
        chk("lat_k2_data", 32'(bus.wr_data), 32'hA53C);
        chk("lat_k2_addr", 32'(bus.wr_addr), 0);
        tick(1);
        chk("lat_k3", 32'(bus.wr_en), 0);
        chk("lat_k3_hold", 32'(bus.wr_data), 32'hA53C);
        bus.cam_pclk = 1'b0;
        tick(2);
        bus.cam_href = 1'b0;
        tick(4);
        bus.cam_vsync = 1'b1;
        tick(8);
        chk("lat_nwr", n_wr - b0, 1);

        // asynchronous reset after five writes
        b0 = n_wr;
        cnt = '0;
        vs_fall();
        send_line(8, cnt);
        bus.cam_href = 1'b1;
        tick(2);
        send_byte(cnt);
        send_byte(cnt + 8'd1);
        cnt = cnt + 8'd2;
        bus.cam_pclk = 1'b0;
        tick(3);
        chk("prerst_nwr", n_wr - b0, 5);
        chk("prerst_addr", 32'(bus.wr_addr), 4);
        rst = 1'b1;
        #1;
        chk("midrst_wr_addr", 32'(bus.wr_addr), 0);
        chk("midrst_wr_data", 32'(bus.wr_data), 0);
        chk("midrst_wr_en", 32'(bus.wr_en), 0);
        tick(2);
        rst = 1'b0;
        b0 = n_wr;
        f0 = n_fd;
        for (int i = 0; i < 6; i++) begin
            send_byte(cnt);
            cnt = cnt + 8'd1;
        end
        bus.cam_pclk = 1'b0;
        tick(2);
        bus.cam_href = 1'b0;
        tick(4);
        send_line(8, cnt);
        bus.cam_vsync = 1'b1;
        tick(8);
        chk("postrst_nwr", n_wr - b0, 0);
        chk("postrst_fdone", n_fd - f0, 0);
        run_vec(vecs[0], 6);

        // init_done dropped mid-line
        b0 = n_wr;
        f0 = n_fd;
        cnt = '0;
        vs_fall();
        bus.cam_href = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            send_byte(cnt);
            cnt = cnt + 8'd1;
        end
        bus.cam_pclk = 1'b0;
        tick(4);
        chk("drop_pre_nwr", n_wr - b0, 2);
        bus.init_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(cnt);
            cnt = cnt + 8'd1;
        end
        bus.cam_pclk = 1'b0;
        tick(2);
        bus.cam_href = 1'b0;
        tick(4);
        send_line(8, cnt);
        bus.cam_vsync = 1'b1;
        tick(8);
        chk("drop_nwr", n_wr - b0, 2);
        chk("drop_fdone", n_fd - f0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
